// File: rtl/ram_byte_lsu.sv
// ram_byte_lsu
//   Load/store sequencer placed directly in front of an 8-bit wide RAM with
//   a combinational read port. RV32 byte/half/word loads and stores arrive
//   over a valid/ready handshake. Each one is broken into 1, 2 or 4 byte
//   accesses, one per clock. Load bytes are assembled little-endian and
//   sign- or zero-extended. A single-cycle response strobe closes each request.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     When defined, a misaligned half or word request makes no RAM access.
//     It goes straight to the response cycle with rsp_err=1 and rsp_rdata=0.
//     When undefined, every address is executed byte-serially with
//     wrap-around, and rsp_err is tied low.
//
// Ports
//   clk          in   clock, all state on the rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  request can be accepted (idle only)
//   req_we       in   1 = store, 0 = load
//   req_funct3   in   [1:0] size (00 byte, 01 half, 1x word), [2] unsigned load
//   req_addr     in   start byte address
//   req_wdata    in   store data, bytes taken from [7:0] upward
//   rsp_valid    out  one-cycle response strobe
//   rsp_rdata    out  extended load data, 0 for stores and errors
//   rsp_err      out  misalign error (feature macro only)
//   ram_address  out  RAM byte address
//   ram_din      out  RAM write data
//   ram_we       out  RAM write enable
//   ram_dout     in   RAM read data (combinational on ram_address)
module ram_byte_lsu #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] XFER = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic              l_we;
  logic [2:0]        l_f3;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;
  logic [31:0]       asm_q;

  logic [1:0]        last_cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        wbyte;
  logic              err_flag;

  // Sign bit is masked by funct3[2] for unsigned loads. The upper assembly
  // bytes are already zero because they are cleared on accept.
  function automatic logic [31:0] extend(input logic [31:0] a, input logic [2:0] f3);
    if (f3[1])
      return a;
    else if (f3[0])
      return {{16{a[15] & ~f3[2]}}, a[15:0]};
    else
      return {{24{a[7] & ~f3[2]}}, a[7:0]};
  endfunction

  assign last_cnt = l_f3[1] ? 2'd3 : (l_f3[0] ? 2'd1 : 2'd0);
  // Natural ADDR_W-bit overflow gives the modulo-depth wrap.
  assign cur_addr = l_addr + {{(ADDR_W-2){1'b0}}, cnt};

  always_comb begin
    wbyte = 8'h00;
    unique case (cnt)
      2'd0:    wbyte = l_wdata[7:0];
      2'd1:    wbyte = l_wdata[15:8];
      2'd2:    wbyte = l_wdata[23:16];
      default: wbyte = l_wdata[31:24];
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  logic req_mis;
  assign req_mis  = (req_funct3[1] && (req_addr[1:0] != 2'b00)) ||
                    ((req_funct3[1:0] == 2'b01) && req_addr[0]);
  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      l_we    <= 1'b0;
      l_f3    <= 3'd0;
      l_addr  <= '0;
      l_wdata <= 32'd0;
      asm_q   <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            l_we    <= req_we;
            l_f3    <= req_funct3;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            cnt     <= 2'd0;
            asm_q   <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= req_mis;
            state   <= req_mis ? RESP : XFER;
`else
            state   <= XFER;
`endif
          end
        end
        XFER: begin
          if (!l_we) begin
            unique case (cnt)
              2'd0:    asm_q[7:0]   <= ram_dout;
              2'd1:    asm_q[15:8]  <= ram_dout;
              2'd2:    asm_q[23:16] <= ram_dout;
              default: asm_q[31:24] <= ram_dout;
            endcase
          end
          // cnt stays at the last byte so the final address is held during RESP.
          if (cnt == last_cnt)
            state <= RESP;
          else
            cnt <= cnt + 2'd1;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    req_ready   = (state == IDLE);
    rsp_valid   = (state == RESP);
    ram_we      = (state == XFER) && l_we;
    ram_din     = ram_we ? wbyte : 8'h00;
    ram_address = (state == IDLE) ? '0 : cur_addr;
    rsp_err     = (state == RESP) && err_flag;
    rsp_rdata   = ((state == RESP) && !l_we && !err_flag) ? extend(asm_q, l_f3) : 32'd0;
  end

endmodule

// File: tb/tb_ram_byte_lsu.sv
module tb_ram_byte_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  ram_address;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  int n_cmp = 0;
  int n_bad = 0;

  // RAM attached to the sequencer: synchronous write, combinational read.
  logic [7:0] ram [64] = '{default: 8'h00};
  // Expected RAM contents, updated per completed transaction.
  logic [7:0] ref_mem [64] = '{default: 8'h00};

  always @(posedge clk) if (ram_we) ram[ram_address] <= ram_din;
  assign ram_dout = ram[ram_address];

  ram_byte_lsu #(.ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_address(ram_address), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [5:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic logic is_mis(input logic [2:0] f3, input logic [5:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    int n = nbytes(f3);
    return ((n == 4) && (addr % 4 != 0)) || ((n == 2) && (addr % 2 != 0));
`else
    return 1'b0;
`endif
  endfunction

  // Little-endian gather from the expected memory, then extend by value.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [5:0] addr);
    int n = nbytes(f3);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v + (32'(ref_mem[(int'(addr) + i) % 64]) << (8 * i));
    if (!f3[2]) begin
      if (n == 1 && v >= 32'd128)   v = v + 32'hFFFFFF00;
      if (n == 2 && v >= 32'd32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [5:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd);
    int n, lat, wc;
    logic mis, got;
    logic [31:0] exp_rd;
    n = nbytes(f3);
    mis = is_mis(f3, addr);
    exp_rd = (we || mis) ? 32'd0 : model_load(f3, addr);
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    // Scramble request inputs after the handshake; they must not matter.
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = 6'($urandom); req_wdata = $urandom;
    got = 0; lat = 0; wc = 0; rd = 32'd0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1; lat = c; rd = rsp_rdata;
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, mis);
        chk("resp_we", ram_we, 0);
        chk("resp_din", ram_din, 0);
        chk("resp_ready", req_ready, 0);
        break;
      end
      chk("xfer_addr", ram_address, (int'(addr) + c - 1) % 64);
      chk("xfer_we", ram_we, we);
      chk("xfer_din", ram_din, we ? ((wd >> (8 * (c - 1))) & 32'hFF) : 32'd0);
      if (ram_we) wc++;
    end
    chk("rsp_seen", got, 1);
    chk("latency", lat, mis ? 1 : n + 1);
    chk("byte_writes", wc, (we && !mis) ? n : 0);
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("ready_back", req_ready, 1);
    chk("idle_addr", ram_address, 0);
    if (we && !mis)
      for (int i = 0; i < n; i++)
        ref_mem[(int'(addr) + i) % 64] = 8'(wd >> (8 * i));
  endtask

  initial begin
    logic [31:0] rd, r1, r2;
    logic        seen1, seen2;
    int          lowc;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 6'd0; req_wdata = 32'd0;

    // Reset state
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_din", ram_din, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a word store: two bytes land, the rest is aborted
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 6'h10;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("midxfer_we_before", ram_we, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", ram_we, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_addr", ram_address, 0);
    chk("midrst_din", ram_din, 0);
    ref_mem[6'h10] = 8'h0D;
    ref_mem[6'h11] = 8'hF0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    tbl.push_back('{"lw_after_reset", 1'b0, 3'b010, 6'h10, 32'h0, 32'h0000F00D});
    tbl.push_back('{"sw_04",          1'b1, 3'b010, 6'h04, 32'hDEADBEEF, 32'h0});
    tbl.push_back('{"lb_07",          1'b0, 3'b000, 6'h07, 32'h0, 32'hFFFFFFDE});
    tbl.push_back('{"lbu_07",         1'b0, 3'b100, 6'h07, 32'h0, 32'h000000DE});
    tbl.push_back('{"lh_06",          1'b0, 3'b001, 6'h06, 32'h0, 32'hFFFFDEAD});
    tbl.push_back('{"lw_04",          1'b0, 3'b010, 6'h04, 32'h0, 32'hDEADBEEF});
    tbl.push_back('{"lhu_04",         1'b0, 3'b101, 6'h04, 32'h0, 32'h0000BEEF});
    tbl.push_back('{"lh_04",          1'b0, 3'b001, 6'h04, 32'h0, 32'hFFFFBEEF});
    tbl.push_back('{"lw_f3_111",      1'b0, 3'b111, 6'h04, 32'h0, 32'hDEADBEEF});
    tbl.push_back('{"sb_08",          1'b1, 3'b000, 6'h08, 32'hFFFFFF80, 32'h0});
    tbl.push_back('{"lb_08",          1'b0, 3'b000, 6'h08, 32'h0, 32'hFFFFFF80});
    tbl.push_back('{"lbu_08",         1'b0, 3'b100, 6'h08, 32'h0, 32'h00000080});
    tbl.push_back('{"sh_f3_101_0a",   1'b1, 3'b101, 6'h0A, 32'hAAAA7F01, 32'h0});
    tbl.push_back('{"lh_0a",          1'b0, 3'b001, 6'h0A, 32'h0, 32'h00007F01});
`ifndef LSU_MISALIGN_TRAP_EN
    tbl.push_back('{"sh_wrap_3f",     1'b1, 3'b001, 6'h3F, 32'h00001234, 32'h0});
    tbl.push_back('{"lhu_wrap_3f",    1'b0, 3'b101, 6'h3F, 32'h0, 32'h00001234});
    tbl.push_back('{"lw_wrap_3e",     1'b0, 3'b010, 6'h3E, 32'h0, 32'h00123400});
`endif
    foreach (tbl[i]) begin
      run_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd);
      chk(tbl[i].name, rd, tbl[i].exp);
    end
`ifndef LSU_MISALIGN_TRAP_EN
    chk("mem_3f", ram[6'h3F], 8'h34);
    chk("mem_00", ram[6'h00], 8'h12);
`else
    run_req(1'b0, 3'b010, 6'h05, 32'h0, rd);
    chk("lw_mis_05", rd, 32'h0);
`endif

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 6'h07;
    @(posedge clk);
    #1;
    req_addr = 6'h08;
    lowc = 0; seen1 = 0; r1 = 32'd0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) begin seen1 = 1; r1 = rsp_rdata; end
      if (req_ready) break;
      lowc++;
    end
    chk("b2b_ready_low_cycles", lowc, 2);
    chk("b2b_rsp1_seen", seen1, 1);
    chk("b2b_rsp1", r1, model_load(3'b000, 6'h07));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen2 = 0; r2 = 32'd0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) begin seen2 = 1; r2 = rsp_rdata; break; end
    end
    chk("b2b_rsp2_seen", seen2, 1);
    chk("b2b_rsp2", r2, model_load(3'b000, 6'h08));
    @(negedge clk);

    // Randomized traffic against the memory model
    for (int k = 0; k < 300; k++)
      run_req(1'($urandom), 3'($urandom), 6'($urandom), $urandom, rd);
    for (int i = 0; i < 64; i++)
      chk("final_mem", ram[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
